// File: rtl/car_pair_scheduler.sv
// Sequential front end for the CarCollision datapath: snapshots N car states on start,
// walks every unordered pair (i<j) over a valid/ready request channel and writes hit velocities back in place.
module car_pair_scheduler #(
    parameter int N_CARS = 4,
    parameter int IDX_W  = 2,
    parameter int X_W    = 16,
    parameter int Y_W    = 16,
    parameter int V_W    = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [N_CARS*X_W-1:0] i_car_x,
    input  logic [N_CARS*Y_W-1:0] i_car_y,
    input  logic [N_CARS*V_W-1:0] i_car_v_x,
    input  logic [N_CARS*V_W-1:0] i_car_v_y,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [X_W-1:0]        o_car1_x,
    output logic [Y_W-1:0]        o_car1_y,
    output logic [X_W-1:0]        o_car2_x,
    output logic [Y_W-1:0]        o_car2_y,
    output logic [V_W-1:0]        o_car1_v_x,
    output logic [V_W-1:0]        o_car1_v_y,
    output logic [V_W-1:0]        o_car2_v_x,
    output logic [V_W-1:0]        o_car2_v_y,
    input  logic                  i_rsp_valid,
    input  logic                  i_rsp_hit,
    input  logic [V_W-1:0]        i_rsp_car1_v_x,
    input  logic [V_W-1:0]        i_rsp_car1_v_y,
    input  logic [V_W-1:0]        i_rsp_car2_v_x,
    input  logic [V_W-1:0]        i_rsp_car2_v_y,
    output logic [N_CARS*V_W-1:0] o_car_v_x,
    output logic [N_CARS*V_W-1:0] o_car_v_y,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [7:0]            o_hit_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_CARS - 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_CARS - 2);

    state_t state_reg, state_next;

    logic [X_W-1:0] x_reg  [N_CARS];
    logic [Y_W-1:0] y_reg  [N_CARS];
    logic [V_W-1:0] vx_reg [N_CARS];
    logic [V_W-1:0] vy_reg [N_CARS];

    logic [X_W-1:0] in_x  [N_CARS];
    logic [Y_W-1:0] in_y  [N_CARS];
    logic [V_W-1:0] in_vx [N_CARS];
    logic [V_W-1:0] in_vy [N_CARS];

    logic [IDX_W-1:0] i_reg, i_next;
    logic [IDX_W-1:0] j_reg, j_next;
    logic [7:0]       hit_count_reg, hit_count_next;
    logic             load;
    logic             write_back;

    // Unpack the flat input buses and pack the velocity registers back out.
    genvar gi;
    generate
        for (gi = 0; gi < N_CARS; gi++) begin : g_car_io
            assign in_x[gi]                   = i_car_x[gi*X_W +: X_W];
            assign in_y[gi]                   = i_car_y[gi*Y_W +: Y_W];
            assign in_vx[gi]                  = i_car_v_x[gi*V_W +: V_W];
            assign in_vy[gi]                  = i_car_v_y[gi*V_W +: V_W];
            assign o_car_v_x[gi*V_W +: V_W]   = vx_reg[gi];
            assign o_car_v_y[gi*V_W +: V_W]   = vy_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        i_next         = i_reg;
        j_next         = j_reg;
        hit_count_next = hit_count_reg;
        load           = 1'b0;
        write_back     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    load           = 1'b1;
                    i_next         = '0;
                    j_next         = IDX_W'(1);
                    hit_count_next = '0;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (i_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (i_rsp_valid) begin
                    if (i_rsp_hit) begin
                        write_back = 1'b1;
                        if (hit_count_reg != 8'hFF) begin
                            hit_count_next = hit_count_reg + 8'd1;
                        end
                    end
                    if (j_reg == LAST_J) begin
                        if (i_reg == LAST_I) begin
                            state_next = DONE;
                        end else begin
                            i_next     = i_reg + IDX_W'(1);
                            j_next     = i_reg + IDX_W'(2);
                            state_next = ISSUE;
                        end
                    end else begin
                        j_next     = j_reg + IDX_W'(1);
                        state_next = ISSUE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            i_reg         <= '0;
            j_reg         <= '0;
            hit_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            i_reg         <= i_next;
            j_reg         <= j_next;
            hit_count_reg <= hit_count_next;
        end
    end

    // Positions only change on a snapshot; velocities also take the collision result for the current pair.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_CARS; k++) begin
                x_reg[k]  <= '0;
                y_reg[k]  <= '0;
                vx_reg[k] <= '0;
                vy_reg[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < N_CARS; k++) begin
                x_reg[k]  <= in_x[k];
                y_reg[k]  <= in_y[k];
                vx_reg[k] <= in_vx[k];
                vy_reg[k] <= in_vy[k];
            end
        end else if (write_back) begin
            for (int k = 0; k < N_CARS; k++) begin
                if (i_reg == IDX_W'(k)) begin
                    vx_reg[k] <= i_rsp_car1_v_x;
                    vy_reg[k] <= i_rsp_car1_v_y;
                end else if (j_reg == IDX_W'(k)) begin
                    vx_reg[k] <= i_rsp_car2_v_x;
                    vy_reg[k] <= i_rsp_car2_v_y;
                end
            end
        end
    end

    // All outputs decode from registers, so the payload is stable for the whole request.
    assign o_req_valid = (state_reg == ISSUE);
    assign o_busy      = (state_reg != IDLE);
    assign o_done      = (state_reg == DONE);
    assign o_hit_count = hit_count_reg;

    assign o_car1_x   = x_reg[i_reg];
    assign o_car1_y   = y_reg[i_reg];
    assign o_car1_v_x = vx_reg[i_reg];
    assign o_car1_v_y = vy_reg[i_reg];
    assign o_car2_x   = x_reg[j_reg];
    assign o_car2_y   = y_reg[j_reg];
    assign o_car2_v_x = vx_reg[j_reg];
    assign o_car2_v_y = vy_reg[j_reg];

endmodule
